// File: rtl/input_mem_sched_if.sv
// Handshake and status bundle between the ping-pong scheduler and its environment
// (command source, data source, systolic array, and the two bank controllers).
interface input_mem_sched_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TILE_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [TILE_WIDTH-1:0] cmd_num_tiles;
  logic [DATA_WIDTH-1:0] cmd_num_row;
  logic                  src_valid;
  logic                  sa_ready;
  logic [DATA_WIDTH-1:0] num_row;
  logic [1:0]            wr_start;
  logic [1:0]            wr_done;
  logic [1:0]            rd_start;
  logic                  busy;
  logic                  done;
  logic [TILE_WIDTH-1:0] tiles_done;
  logic                  err;

  modport master (
    output cmd_valid, cmd_num_tiles, cmd_num_row, src_valid, sa_ready, wr_done,
    input  cmd_ready, num_row, wr_start, rd_start, busy, done, tiles_done, err
  );

  modport slave (
    input  cmd_valid, cmd_num_tiles, cmd_num_row, src_valid, sa_ready, wr_done,
    output cmd_ready, num_row, wr_start, rd_start, busy, done, tiles_done, err
  );
endinterface

// File: rtl/input_mem_sched.sv
// Ping-pong tile scheduler: loads tile k+1 into one input bank while the
// systolic array sweeps tile k out of the other, then reports job completion.
module input_mem_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int ACCUM_ROW  = 256,
  parameter int TILE_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  input_mem_sched_if.slave  bus
);

  typedef enum logic {S_IDLE, S_RUN} fsm_t;
  typedef enum logic [1:0] {B_EMPTY, B_LOADING, B_FULL, B_READING} bank_t;

  localparam logic [DATA_WIDTH-1:0] ACCUM_ROW_W = DATA_WIDTH'(ACCUM_ROW);
  localparam logic [DATA_WIDTH:0]   ONE_W       = (DATA_WIDTH+1)'(1);

  fsm_t                  state_reg, state_next;
  logic [TILE_WIDTH-1:0] nt_reg;
  logic [TILE_WIDTH-1:0] tiles_issued_reg;
  logic [TILE_WIDTH-1:0] tiles_done_reg;
  logic [DATA_WIDTH-1:0] nr_reg;
  logic [DATA_WIDTH-1:0] nr_clamped;
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic                  rd_active_reg;
  logic [DATA_WIDTH:0]   rd_cnt_reg;
  logic [DATA_WIDTH:0]   rd_len;
  logic                  err_reg;

  logic       cmd_ready_int, busy_int, done_int;
  logic       accept, load_issue, read_issue, rd_finish;
  logic [1:0] bank_empty, bank_full, wr_done_bad;
  logic [1:0] wr_start_int, rd_start_int;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept)   state_next = S_RUN;
      S_RUN:  if (done_int) state_next = S_IDLE;
      default:              state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_int = 1'b0;
    busy_int      = 1'b0;
    done_int      = 1'b0;
    case (state_reg)
      S_IDLE: cmd_ready_int = 1'b1;
      S_RUN: begin
        busy_int = 1'b1;
        // A zero-row job can never make progress, so it finishes straight away.
        done_int = (tiles_done_reg == nt_reg) || (nr_reg == '0);
      end
      default: cmd_ready_int = 1'b0;
    endcase
  end

  // ---------------- issue decisions (registered bank state only) ----------------
  assign accept     = bus.cmd_valid && cmd_ready_int;
  assign nr_clamped = (bus.cmd_num_row > ACCUM_ROW_W) ? ACCUM_ROW_W : bus.cmd_num_row;
  assign rd_len     = {nr_reg, 1'b0} - ONE_W;
  assign rd_finish  = rd_active_reg && (rd_cnt_reg == ONE_W);

  assign load_issue = (state_reg == S_RUN) && (nr_reg != '0) &&
                      (tiles_issued_reg < nt_reg) && bank_empty[wr_ptr_reg] && bus.src_valid;
  assign read_issue = (state_reg == S_RUN) && bank_full[rd_ptr_reg] &&
                      bus.sa_ready && !rd_active_reg;

  assign wr_start_int = load_issue ? (2'b01 << wr_ptr_reg) : 2'b00;
  assign rd_start_int = read_issue ? (2'b01 << rd_ptr_reg) : 2'b00;

  // ---------------- per-bank state ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic BANK_ID = 1'(gi);
      bank_t bank_reg, bank_next;

      always_ff @(posedge clk) begin
        if (rst) bank_reg <= B_EMPTY;
        else     bank_reg <= bank_next;
      end

      // Each event needs a distinct current state, so at most one can apply per cycle.
      always_comb begin
        bank_next = bank_reg;
        if (wr_start_int[gi])
          bank_next = B_LOADING;
        else if (bus.wr_done[gi] && (bank_reg == B_LOADING))
          bank_next = B_FULL;
        else if (rd_start_int[gi])
          bank_next = B_READING;
        else if (rd_finish && (rd_ptr_reg == BANK_ID))
          bank_next = B_EMPTY;
      end

      assign bank_empty[gi]  = (bank_reg == B_EMPTY);
      assign bank_full[gi]   = (bank_reg == B_FULL);
      assign wr_done_bad[gi] = bus.wr_done[gi] && (bank_reg != B_LOADING);
    end
  endgenerate

  // ---------------- job datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      nt_reg           <= '0;
      nr_reg           <= '0;
      tiles_issued_reg <= '0;
      tiles_done_reg   <= '0;
      wr_ptr_reg       <= 1'b0;
      rd_ptr_reg       <= 1'b0;
      rd_active_reg    <= 1'b0;
      rd_cnt_reg       <= '0;
      err_reg          <= 1'b0;
    end else if (accept) begin
      nt_reg           <= bus.cmd_num_tiles;
      nr_reg           <= nr_clamped;
      tiles_issued_reg <= '0;
      tiles_done_reg   <= '0;
      wr_ptr_reg       <= 1'b0;
      rd_ptr_reg       <= 1'b0;
      rd_active_reg    <= 1'b0;
      rd_cnt_reg       <= '0;
      err_reg          <= (nr_clamped == '0) || (|wr_done_bad);
    end else begin
      if (|wr_done_bad)
        err_reg <= 1'b1;
      if (load_issue) begin
        wr_ptr_reg       <= ~wr_ptr_reg;
        tiles_issued_reg <= tiles_issued_reg + 1'b1;
      end
      // The sweep counter is busy from issue until the edge where it reaches zero.
      if (read_issue) begin
        rd_active_reg <= 1'b1;
        rd_cnt_reg    <= rd_len;
      end else if (rd_active_reg) begin
        rd_cnt_reg <= rd_cnt_reg - ONE_W;
        if (rd_finish) begin
          rd_active_reg  <= 1'b0;
          rd_ptr_reg     <= ~rd_ptr_reg;
          tiles_done_reg <= tiles_done_reg + 1'b1;
        end
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.cmd_ready  = cmd_ready_int;
  assign bus.busy       = busy_int;
  assign bus.done       = done_int;
  assign bus.wr_start   = wr_start_int;
  assign bus.rd_start   = rd_start_int;
  assign bus.num_row    = nr_reg;
  assign bus.tiles_done = tiles_done_reg;
  assign bus.err        = err_reg;

endmodule
